mult_div_unit: RTL and testbench

Iterative HI/LO multiply/divide unit for the single-issue MIPS datapath. It sits directly downstream of the register file and consumes its two read ports (rs value on `out1`, rt value on `out2`). It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers. The control unit stalls the pipeline while `busy` is high; MFHI/MFLO read `hi`/`lo` directly.

---
 rtl/mult_div_unit.sv | 124 ++++++++++++
 tb/tb_mult_div_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide: 33-cycle MULT/DIV (busy stalls the pipe), single-edge MTHI/MTLO.
// start is only honoured in IDLE; requests made while busy are dropped.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic               r_busy, r_done, r_is_div, r_neg_q, r_neg_r, r_dz;
   logic [WIDTH-1:0]   r_hi, r_lo, r_a, r_b, r_rem;
   logic [2*WIDTH-1:0] r_acc;

   logic               w_a_neg, w_b_neg, w_qbit;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_sub, w_quo, w_rmd;
   logic [WIDTH:0]     w_sum, w_shift;
   logic [2*WIDTH-1:0] w_acc_next, w_prod;

   always_comb begin
      // op[0]==0 selects the signed MULT/DIV variants
      w_a_neg    = !op[0] && rs_val[WIDTH-1];
      w_b_neg    = !op[0] && rt_val[WIDTH-1];
      w_a_mag    = w_a_neg ? -rs_val : rs_val;
      w_b_mag    = w_b_neg ? -rt_val : rt_val;
      w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
      w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
      // Partial remainder is one bit wider than the divisor before the trial subtract
      w_shift    = {r_rem, r_acc[WIDTH-1]};
      w_qbit     = (w_shift >= {1'b0, r_b});
      w_sub      = w_shift[WIDTH-1:0] - r_b;
      w_prod     = r_neg_q ? -r_acc : r_acc;
      w_quo      = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_rmd      = r_neg_r ? -r_rem : r_rem;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_rem    <= '0;
         r_acc    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  case (op)
                     3'b000, 3'b001, 3'b010, 3'b011: begin
                        r_is_div <= op[1];
                        r_a      <= w_a_mag;
                        r_b      <= w_b_mag;
                        r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                        r_rem    <= '0;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_dz     <= (rt_val == '0);
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                     end
                     3'b100:  r_hi <= rs_val;
                     3'b101:  r_lo <= rs_val;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               if (r_is_div) begin
                  r_rem              <= w_qbit ? w_sub : w_shift[WIDTH-1:0];
                  r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_qbit};
               end else begin
                  r_acc <= w_acc_next;
               end
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH-1)) r_state <= FIX;
            end
            FIX: begin
               if (!r_is_div) begin
                  {r_hi, r_lo} <= w_prod;
               end else if (r_dz) begin
                  // Divide by zero returns all-ones quotient and the original dividend
                  r_lo <= '1;
                  r_hi <= r_neg_r ? -r_a : r_a;
               end else begin
                  r_lo <= w_quo;
                  r_hi <= w_rmd;
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, corner sequences, and random ops against an arithmetic model.
module tb_mult_div_unit;
   logic        clock, reset, start;
   logic [2:0]  op;
   logic [31:0] rs_val, rt_val, hi, lo;
   logic        busy, done;

   int n_tests = 0;
   int n_fail  = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
      .hi(hi), .lo(lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, exp_hi, exp_lo;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference model: plain 64-bit integer arithmetic, returns {hi, lo}
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      r  = '0;
      case (o)
         3'd0: r = sa * sb;
         3'd1: r = ua * ub;
         3'd2: begin
            if (b == 0) r = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
            else begin
               r[31:0]  = 32'(sa / sb);
               r[63:32] = 32'(sa % sb);
            end
         end
         3'd3: begin
            if (b == 0) r = {a, 32'hFFFF_FFFF};
            else begin
               r[31:0]  = 32'(ua / ub);
               r[63:32] = 32'(ua % ub);
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Caller must be at a negedge; returns at the negedge after busy falls.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int inj,
                        output int lat, output logic d, output logic [31:0] h, output logic [31:0] l);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      chk("busy_low_at_start", {63'b0, busy}, 64'd0);
      @(negedge clock);
      start = 1'b0;
      lat = 0;
      while (busy === 1'b1 && lat < 100) begin
         lat++;
         if (lat == inj) begin
            start = 1'b1; op = 3'b010; rs_val = 32'd9; rt_val = 32'd3;
         end
         @(negedge clock);
         start = 1'b0;
      end
      d = done; h = hi; l = lo;
   endtask

   vec_t        tbl[10];
   int          lat;
   logic        d, saw;
   logic [31:0] h, l;
   logic [2:0]  ro;
   logic [31:0] ra, rb;

   initial begin
      tbl[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      tbl[1] = '{3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
      tbl[2] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
      tbl[3] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      tbl[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
      tbl[5] = '{3'd3, 32'd7,         32'd2,         32'd1,         32'd3};
      tbl[6] = '{3'd3, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
      tbl[7] = '{3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
      tbl[8] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      tbl[9] = '{3'd0, 32'd7,         32'd0,         32'd0,         32'd0};

      reset = 1'b1; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("reset_busy", {63'b0, busy}, 64'd0);
      chk("reset_done", {63'b0, done}, 64'd0);
      chk("reset_hilo", {hi, lo}, 64'd0);

      for (int i = 0; i < 10; i++) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, lat, d, h, l);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
         chk($sformatf("vec%0d_done", i), {63'b0, d}, 64'd1);
         chk($sformatf("vec%0d_hi", i), {32'b0, h}, {32'b0, tbl[i].exp_hi});
         chk($sformatf("vec%0d_lo", i), {32'b0, l}, {32'b0, tbl[i].exp_lo});
         @(negedge clock);
         chk($sformatf("vec%0d_done_drop", i), {63'b0, done}, 64'd0);
      end

      // Back-to-back: second start presented in the done cycle
      do_op(3'd1, 32'd2, 32'd3, 0, lat, d, h, l);
      chk("b2b_first", {h, l}, 64'd6);
      do_op(3'd3, 32'd100, 32'd7, 0, lat, d, h, l);
      chk("b2b_latency", 64'(lat), 64'd33);
      chk("b2b_second", {h, l}, {32'd2, 32'd14});

      // Start while busy is ignored
      @(negedge clock);
      do_op(3'd1, 32'd2, 32'd3, 10, lat, d, h, l);
      chk("ignored_start_latency", 64'(lat), 64'd33);
      chk("ignored_start_result", {h, l}, 64'd6);
      @(negedge clock);
      chk("ignored_start_no_rerun", {63'b0, busy}, 64'd0);

      // Reset mid-operation discards the result
      start = 1'b1; op = 3'd4; rs_val = 32'h55;
      @(negedge clock);
      start = 1'b1; op = 3'd1; rs_val = 32'd2; rt_val = 32'd3;
      @(negedge clock);
      start = 1'b0;
      repeat (14) @(negedge clock);
      chk("pre_reset_busy", {63'b0, busy}, 64'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("midrst_busy", {63'b0, busy}, 64'd0);
      chk("midrst_hilo", {hi, lo}, 64'd0);
      saw = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
      end
      chk("midrst_no_done", {63'b0, saw}, 64'd0);

      // MTHI then MTLO on consecutive cycles, then reserved ops
      start = 1'b1; op = 3'd4; rs_val = 32'hDEAD_BEEF;
      @(negedge clock);
      chk("mthi_hi", {32'b0, hi}, {32'b0, 32'hDEAD_BEEF});
      chk("mthi_lo_kept", {32'b0, lo}, 64'd0);
      chk("mthi_busy_done", {62'b0, busy, done}, 64'd0);
      op = 3'd5; rs_val = 32'h2;
      @(negedge clock);
      chk("mtlo_hilo", {hi, lo}, {32'hDEAD_BEEF, 32'h2});
      chk("mtlo_busy_done", {62'b0, busy, done}, 64'd0);
      op = 3'd6; rs_val = 32'h1111; rt_val = 32'h2;
      @(negedge clock);
      op = 3'd7;
      @(negedge clock);
      start = 1'b0;
      chk("reserved_hilo", {hi, lo}, {32'hDEAD_BEEF, 32'h2});
      chk("reserved_busy", {63'b0, busy}, 64'd0);

      // Random operations against the model
      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 3));
         ra = pick();
         rb = pick();
         @(negedge clock);
         do_op(ro, ra, rb, 0, lat, d, h, l);
         chk($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb), {h, l}, model(ro, ra, rb));
         chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'd33);
         chk($sformatf("rnd%0d_done", i), {63'b0, d}, 64'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
